// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and default widths for the MAC job sequencer
package mac_pkg;

    localparam int DATA_WIDTH_C = 16;
    localparam int ACC_WIDTH_C  = 40;
    localparam int LEN_WIDTH_C  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_START,
        ST_WAIT,
        ST_ACC,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/mac_job_counter.sv
// rtl/mac_job_counter.sv - remaining-element down-counter with load, decrement and zero/one flags
module mac_job_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             one
);

    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - ONE_C;
        end
    end

    assign zero = (count == '0);
    assign one  = (count == ONE_C);

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dot-product job controller driving booth_multiplier and accumulator_unit
// Optional build macro ZERO_SKIP_EN: pairs with a zero operand bypass the multiplier.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_C,
    parameter int ACC_WIDTH  = ACC_WIDTH_C,
    parameter int LEN_WIDTH  = LEN_WIDTH_C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_m,
    output logic [DATA_WIDTH-1:0] mul_q,
    input  logic                  mul_ready,
    output logic                  acc_clr,
    output logic                  acc_en,
    input  logic [ACC_WIDTH-1:0]  acc_value,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  busy
);

    seq_state_e           state;
    seq_state_e           state_next;
    logic                 armed;
    logic                 accept;
    logic                 skip_pair;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic                 cnt_one;
    logic [LEN_WIDTH-1:0] elem_cnt;

    assign accept = op_valid && op_ready;

`ifdef ZERO_SKIP_EN
    assign skip_pair = (op_a == '0) || (op_b == '0);
`else
    assign skip_pair = 1'b0;
`endif

    mac_job_counter #(
        .WIDTH (LEN_WIDTH)
    ) u_job_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cfg_len),
        .dec      (cnt_dec),
        .count    (elem_cnt),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (job_start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = cnt_zero ? ST_DONE : ST_FETCH;
            ST_FETCH: begin
                if (accept) begin
                    if (skip_pair) state_next = cnt_one ? ST_DONE : ST_FETCH;
                    else           state_next = ST_START;
                end
            end
            ST_START: state_next = ST_WAIT;
            // A ready that never dropped after START belongs to a previous operation.
            ST_WAIT:  if (armed && mul_ready) state_next = ST_ACC;
            ST_ACC:   state_next = cnt_one ? ST_DONE : ST_FETCH;
            ST_DONE:  if (res_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state == ST_FETCH);
        mul_start = (state == ST_START);
        acc_clr   = (state == ST_CLEAR);
        acc_en    = (state == ST_ACC);
        res_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        res_data  = (state == ST_DONE) ? acc_value : '0;
        cnt_load  = (state == ST_IDLE) && job_start;
        cnt_dec   = (state == ST_ACC) || ((state == ST_FETCH) && accept && skip_pair);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (state == ST_START) begin
            armed <= 1'b0;
        end else if ((state == ST_WAIT) && !mul_ready) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_m <= '0;
            mul_q <= '0;
        end else if ((state == ST_FETCH) && accept) begin
            mul_m <= op_a;
            mul_q <= op_b;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - randomized self-checking bench for mac_sequencer with multiplier/accumulator models
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_start;
    logic [7:0]  cfg_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mul_start;
    logic [15:0] mul_m;
    logic [15:0] mul_q;
    logic        mul_ready = 1'b1;
    logic        acc_clr;
    logic        acc_en;
    logic [39:0] acc_value;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_data;
    logic        busy;

    int passed = 0;
    int total  = 0;

    mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_start (job_start),
        .cfg_len   (cfg_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_start (mul_start),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_ready (mul_ready),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .acc_value (acc_value),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier: drops ready on start, raises it mul_lat cycles later with the product.
    // Accumulator: clear, or add the sign-extended product.
    int                 mul_lat = 2;
    int                 lat_cnt = 0;
    logic signed [31:0] prod_m  = '0;
    logic        [39:0] acc_m   = '0;

    always @(posedge clk) begin
        if (mul_start) begin
            prod_m    <= $signed(mul_m) * $signed(mul_q);
            lat_cnt   <= mul_lat;
            mul_ready <= 1'b0;
        end else if (lat_cnt > 1) begin
            lat_cnt <= lat_cnt - 1;
        end else if (lat_cnt == 1) begin
            lat_cnt   <= 0;
            mul_ready <= 1'b1;
        end
        if (acc_clr)     acc_m <= '0;
        else if (acc_en) acc_m <= acc_m + {{8{prod_m[31]}}, prod_m};
    end
    assign acc_value = acc_m;

    int n_start = 0, n_acc = 0, n_clr = 0, n_opr = 0;
    always @(negedge clk) begin
        if (mul_start) n_start++;
        if (acc_en)    n_acc++;
        if (acc_clr)   n_clr++;
        if (op_ready)  n_opr++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    shortint pa [16];
    shortint pb [16];

    task automatic send_pair(input shortint a, input shortint b);
        int t = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!op_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("op_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    // Reference result is the plain sum of signed products, wrapped to 40 bits.
    task automatic run_job(input string tag, input int len, input int hold, input bit inject);
        int          s0 = n_start, a0 = n_acc, c0 = n_clr;
        int          nz = 0;
        int          exp_starts;
        int          t = 0;
        longint      exp_sum = 0;
        logic [39:0] exp_res;
        @(negedge clk);
        cfg_len   = 8'(len);
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            send_pair(pa[i], pb[i]);
            exp_sum += longint'(pa[i]) * longint'(pb[i]);
            if (pa[i] != 0 && pb[i] != 0) nz++;
            if (inject && i == 0) begin
                @(negedge clk);
                @(negedge clk);
                check({tag, "_wait_busy"}, 64'(busy), 64'd1);
                check({tag, "_wait_noready"}, 64'(op_ready), 64'd0);
                cfg_len   = 8'd7;
                job_start = 1'b1;
                @(negedge clk);
                job_start = 1'b0;
            end
        end
        exp_res = exp_sum[39:0];
        while (!res_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_res_data"}, 64'(res_data), 64'(exp_res));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(res_data), 64'(exp_res));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
`ifdef ZERO_SKIP_EN
        exp_starts = nz;
`else
        exp_starts = len;
`endif
        check({tag, "_mul_starts"}, 64'(n_start - s0), 64'(exp_starts));
        check({tag, "_acc_ens"}, 64'(n_acc - a0), 64'(exp_starts));
        check({tag, "_acc_clrs"}, 64'(n_clr - c0), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({op_ready, mul_start, acc_clr, acc_en, res_valid, busy}), 64'd0);
        check({tag, "_mul_m"}, 64'(mul_m), 64'd0);
        check({tag, "_mul_q"}, 64'(mul_q), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
    endtask

    initial begin
        int o0, s0, len;
        rst_n     = 1'b0;
        job_start = 1'b0;
        cfg_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Test 1: three signed pairs, sum -21
        pa[0] = 2;  pb[0] = 3;
        pa[1] = -4; pb[1] = 5;
        pa[2] = 7;  pb[2] = -1;
        mul_lat = 2;
        run_job("t1", 3, 0, 1'b0);

        // Test 2: empty job
        o0 = n_opr;
        s0 = n_start;
        @(negedge clk);
        cfg_len   = 8'd0;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        check("t2_clr", 64'(acc_clr), 64'd1);
        check("t2_valid_early", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("t2_valid", 64'(res_valid), 64'd1);
        check("t2_data", 64'(res_data), 64'd0);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("t2_idle", 64'(busy), 64'd0);
        check("t2_no_opready", 64'(n_opr - o0), 64'd0);
        check("t2_no_start", 64'(n_start - s0), 64'd0);

        // Test 3: result held while consumer stalls
        pa[0] = 100;    pb[0] = -300;
        pa[1] = -32768; pb[1] = -32768;
        run_job("t3", 2, 10, 1'b0);

        // Test 4: job_start during WAIT is ignored
        pa[0] = 11; pb[0] = 12;
        pa[1] = -6; pb[1] = 9;
        mul_lat = 4;
        run_job("t4", 2, 1, 1'b1);

        // Test 5: reset mid-WAIT, then a fresh job
        @(negedge clk);
        cfg_len   = 8'd2;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        send_pair(16'sd13, 16'sd17);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        pa[0] = 5; pb[0] = 5;
        run_job("t5", 1, 0, 1'b0);

        // Test 6: zero operand pair
        pa[0] = 0; pb[0] = 9;
        pa[1] = 3; pb[1] = 3;
        mul_lat = 1;
        run_job("t6", 2, 0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                pa[i] = ($urandom_range(0, 3) == 0) ? 16'sd0 : shortint'($urandom);
                pb[i] = ($urandom_range(0, 3) == 0) ? 16'sd0 : shortint'($urandom);
            end
            mul_lat = int'($urandom_range(1, 5));
            run_job("rnd", len, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 64'd0, 64'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
